// File: rtl/execute_unit.sv
// execute_unit: execute stage with single-cycle ALU/shift ops, a 16-step
// shift-add multiply and NZCV flags. It produces a one-cycle write-back pulse.
// Ports: clock, rst (sync, active-high)
//        in_valid/in_ready: handshake with decode
//        op, dest, opA, opB, set_flags: the operation presented by decode
//        wb_we/wb_reg/wb_data: write port pulse to the register file
//        flags: {N,Z,C,V}
//        busy: high while a multiply is in flight
module execute_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [3:0]       dest,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             set_flags,
    output logic             wb_we,
    output logic [3:0]       wb_reg,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORR = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_MVN = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_we;
    logic [3:0]       r_reg;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_flags;

    logic [WIDTH-1:0] r_mcd;
    logic [WIDTH-1:0] r_mpr;
    logic [WIDTH-1:0] r_acc;
    logic [3:0]       r_cnt;
    logic [3:0]       r_mul_dest;
    logic             r_mul_sf;

    logic             w_fire;
    logic             w_is_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;

    logic [4:0]       w_amt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    // Shift results carry one extra bit holding the last bit shifted out:
    // LSL keeps it at the top, LSR/ASR at the bottom.
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;

    logic [WIDTH-1:0] w_res;
    logic             w_we;
    logic             w_upd;
    logic             w_c;
    logic             w_v;

    assign in_ready = !rst && (r_state == S_IDLE);
    assign busy     = (r_state == S_MUL);
    assign wb_we    = r_we;
    assign wb_reg   = r_reg;
    assign wb_data  = r_data;
    assign flags    = r_flags;

    assign w_fire    = in_valid && (r_state == S_IDLE);
    assign w_is_mul  = (op == OP_MUL);
    assign w_last    = (r_cnt == 4'd15);
    assign w_acc_nxt = r_mpr[0] ? (r_acc + r_mcd) : r_acc;

    assign w_amt  = opB[4:0];
    assign w_sum  = {1'b0, opA} + {1'b0, opB};
    assign w_diff = {1'b0, opA} - {1'b0, opB};
    assign w_lsl  = {1'b0, opA} << w_amt;
    assign w_lsr  = {opA, 1'b0} >> w_amt;
    assign w_asr  = $signed({opA, 1'b0}) >>> w_amt;

    always_comb begin
        w_res = '0;
        w_we  = 1'b1;
        w_upd = set_flags;
        w_c   = r_flags[1];
        w_v   = r_flags[0];
        unique case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (opA[15] == opB[15]) && (w_res[15] != opA[15]);
            end
            OP_SUB, OP_CMP: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = !w_diff[WIDTH];
                w_v   = (opA[15] != opB[15]) && (w_res[15] != opA[15]);
                if (op == OP_CMP) begin
                    w_we  = 1'b0;
                    w_upd = 1'b1;
                end
            end
            OP_AND: w_res = opA & opB;
            OP_ORR: w_res = opA | opB;
            OP_EOR: w_res = opA ^ opB;
            OP_MOV: w_res = opB;
            OP_MVN: w_res = ~opB;
            OP_LSL: begin
                w_res = w_lsl[WIDTH-1:0];
                if (w_amt != 5'd0) w_c = w_lsl[WIDTH];
            end
            OP_LSR: begin
                w_res = w_lsr[WIDTH:1];
                if (w_amt != 5'd0) w_c = w_lsr[0];
            end
            OP_ASR: begin
                w_res = w_asr[WIDTH:1];
                if (w_amt != 5'd0) w_c = w_asr[0];
            end
            default: begin
                w_we  = 1'b0;
                w_upd = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_fire && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_reg      <= '0;
            r_data     <= '0;
            r_flags    <= '0;
            r_mcd      <= '0;
            r_mpr      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_mul_dest <= '0;
            r_mul_sf   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_fire && w_is_mul) begin
                    r_mcd      <= opA;
                    r_mpr      <= opB;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_mul_dest <= dest;
                    r_mul_sf   <= set_flags;
                end else if (w_fire) begin
                    r_we <= w_we;
                    if (w_we) begin
                        r_reg  <= dest;
                        r_data <= w_res;
                    end
                    if (w_upd) r_flags <= {w_res[15], w_res == '0, w_c, w_v};
                end
            end else begin
                r_acc <= w_acc_nxt;
                r_mcd <= r_mcd << 1;
                r_mpr <= r_mpr >> 1;
                r_cnt <= r_cnt + 4'd1;
                if (w_last) begin
                    r_we   <= 1'b1;
                    r_reg  <= r_mul_dest;
                    r_data <= w_acc_nxt;
                    if (r_mul_sf) begin
                        r_flags[3] <= w_acc_nxt[15];
                        r_flags[2] <= (w_acc_nxt == '0);
                    end
                end
            end
        end
    end

endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage that consumes the two operands read from the register file and produces the write-back for it. Performs single-cycle ALU/shift operations and a 16-cycle shift-add multiply, keeps the NZCV flags, and drives a one-cycle write pulse (register index plus data) to the register file's write port. A valid/ready handshake lets decode stall while a multiply is in flight.

## Interface

- WIDTH, 16, datapath width; only 16 is supported.
- clock  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents an operation.
- in_ready  output  1  stage can accept; transfer on edge where in_valid && in_ready.
- op  input  4  operation code, see Operation.
- dest  input  4  destination register index, R0–R15.
- opA  input  16  first operand.
- opB  input  16  second operand or shift amount.
- set_flags  input  1  update NZCV for this operation.
- wb_we  output  1  one-cycle write strobe to the register file.
- wb_reg  output  4  register index written.
- wb_data  output  16  data written.
- flags  output  4  {N,Z,C,V}, registered.
- busy  output  1  multiply in progress.

## Operation

- Opcodes: 0 ADD A+B; 1 SUB A−B; 2 AND; 3 ORR; 4 EOR; 5 MOV (B); 6 MVN (~B); 7 LSL A by B[4:0]; 8 LSR; 9 ASR; 10 CMP (A−B, no write-back, flags always updated); 11 MUL (low 16 bits of A×B); 12–15 reserved: accepted, no write-back, flags unchanged.
- All arithmetic modulo 2^16; operands treated as two's complement for V and ASR only.
- Flags (when set_flags=1, or op=CMP): N=result[15]; Z=(result==0). ADD: C=carry out of bit 15, V=signed overflow. SUB/CMP: C=1 when A≥B unsigned (no borrow), V=signed overflow. Shifts: C=last bit shifted out; amount 0 leaves C unchanged; LSL/LSR amount 16 gives C=bit shifted out, >16 gives C=0; ASR ≥16 gives C=A[15]. Logic ops, MOV, MVN, MUL: C and V unchanged. V unchanged for shifts.
- Shift amounts ≥16: LSL/LSR result 0; ASR result all copies of A[15].
- States: IDLE, MUL. IDLE: in_ready=1; non-MUL op executes in the accepting edge; MUL loads multiplicand, multiplier, accumulator=0, counter=0 and enters MUL. MUL: one shift-add step per cycle, counter 0..15; on the edge where counter=15 completes, result written, state returns to IDLE.
- dest=13/14/15 carries no special meaning; written like any other register.
- Write-back and flags for one operation update on the same edge.

## Timing

- Reset (rst=1 at an edge): state IDLE, wb_we=0, wb_reg=0, wb_data=0, flags=0000, busy=0, counter=0. While rst=1, in_ready=0 and inputs ignored. Reset during MUL aborts it: no write-back, flags untouched beyond being cleared.
- in_ready is combinational from state: 1 in IDLE (rst=0), 0 in MUL.
- Single-cycle op accepted at edge k: wb_we=1, wb_reg, wb_data, flags valid in cycle after k; wb_we back to 0 after edge k+1 unless another write-producing op accepted at k+1. Back-to-back throughput one op per cycle.
- MUL accepted at edge k: busy=1 and in_ready=0 in cycles after k through k+16; write-back and flags valid after edge k+16; in_ready=1 in that same cycle, so next op may be accepted at edge k+17.
- CMP and reserved ops: wb_we=0 in the following cycle.
- wb_we is never high for more than one cycle per accepted operation.

## Test plan

- Reset then ADD opA=16'h7FFF opB=16'h0001 dest=2 set_flags=1 -> next cycle wb_we=1, wb_reg=2, wb_data=16'h8000, flags N=1 Z=0 C=0 V=1.
- CMP opA=16'h0005 opB=16'h0005 -> wb_we=0, flags Z=1 C=1 N=0 V=0; SUB 3−5 set_flags=1 -> data 16'hFFFE, C=0, N=1.
- Shifts: LSL 16'h8001 by 1 -> 16'h0002 C=1; ASR 16'h8000 by 20 -> 16'hFFFF C=1; LSR 16'h1234 by 0 -> 16'h1234, C unchanged.
- MUL opA=16'h0123 opB=16'h0045 dest=7 accepted at edge k -> in_ready=0 for 16 cycles, single wb_we pulse after edge k+16, wb_data=16'h4E6F; in_valid held high meanwhile not accepted.
- Back-to-back: five ADDs on consecutive cycles -> five consecutive wb_we pulses with correct reg/data order.
- Assert rst at MUL step 8 -> no wb_we, flags=0000, in_ready=1 in the cycle after rst deasserts, next ADD completes normally.
